// File: rtl/ddc_demixer_pkg.sv
// ddc_demixer_pkg
// Shared constants and helpers for the receive-side fs/4 demixer.
//   T_BITS, F_BITS    : sample width / fractional bits, shared with the transmit path
//   LOG2_DEC          : log2 of the integrate-and-dump decimation factor (legal 2..6)
//   GAIN_BITS, GAIN   : amplitude-correction gain, 1/0.3155 in Q(F_BITS)
//   TX_AMP            : transmit amplitude scale 0.3155 in Q(F_BITS), kept for reference
//   lo_code_e         : LO code encoding, identical to the transmit LO
package ddc_demixer_pkg;

    localparam int T_BITS    = 11;
    localparam int F_BITS    = 9;
    localparam int LOG2_DEC  = 3;
    localparam int GAIN_BITS = 13;

    localparam logic [GAIN_BITS-1:0] GAIN   = 13'd1623;
    localparam logic [T_BITS-1:0]    TX_AMP = 11'd162;

    typedef enum logic [1:0] {
        LO_ZERO = 2'b00,
        LO_POS  = 2'b01,
        LO_NEG  = 2'b10
    } lo_code_e;

    // I branch LO: +1, 0, -1, 0 over phases 0..3
    function automatic lo_code_e lo_i_code(input logic [1:0] phase);
        lo_code_e code;
        case (phase)
            2'd0:    code = LO_POS;
            2'd2:    code = LO_NEG;
            default: code = LO_ZERO;
        endcase
        return code;
    endfunction

    // Q branch LO: 0, +1, 0, -1 over phases 0..3
    function automatic lo_code_e lo_q_code(input logic [1:0] phase);
        lo_code_e code;
        case (phase)
            2'd1:    code = LO_POS;
            2'd3:    code = LO_NEG;
            default: code = LO_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ddc_demixer_if.sv
// ddc_demixer_if
// Sample-in / baseband-out bundle of the demixer.
//   in_i, in_valid, sync_i : real sample stream with qualifier and frame resync
//   out_i, out_q, out_valid: decimated baseband pair with one-cycle pulse
// Modports: master drives samples and observes outputs; slave is the demixer.
interface ddc_demixer_if;
    import ddc_demixer_pkg::*;

    logic signed [T_BITS-1:0] in_i;
    logic                     in_valid;
    logic                     sync_i;
    logic signed [T_BITS-1:0] out_i;
    logic signed [T_BITS-1:0] out_q;
    logic                     out_valid;

    modport master (
        output in_i, in_valid, sync_i,
        input  out_i, out_q, out_valid
    );

    modport slave (
        input  in_i, in_valid, sync_i,
        output out_i, out_q, out_valid
    );

endinterface

// File: rtl/ddc_demixer_integrator.sv
// ddc_integrator
// One mixing branch: LO sign/zero select, integrate-and-dump accumulator and
// the stage-1 register holding the scaled dump result.
//   clk, rst_n : clock, async active-low reset
//   x          : signed input sample
//   lo         : LO code for this sample (+1 / 0 / -1)
//   accept     : sample is valid this cycle
//   restart    : start a fresh frame (sample, if accepted, is its first)
//   dump       : accepted sample closes the frame
//   stage1     : (frame sum) >>> (LOG2_DEC-1), held until the next dump
module ddc_integrator
    import ddc_demixer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [T_BITS-1:0] x,
    input  lo_code_e               lo,
    input  logic                   accept,
    input  logic                   restart,
    input  logic                   dump,
    output logic signed [T_BITS:0] stage1
);

    // A frame sum of DEC full-scale samples fits exactly in T_BITS+LOG2_DEC bits.
    localparam int ACC_W = T_BITS + LOG2_DEC;
    localparam int S1_W  = T_BITS + 1;
    localparam int SHIFT = LOG2_DEC - 1;

    localparam logic signed [T_BITS-1:0] X_MAX = {1'b0, {(T_BITS-1){1'b1}}};
    localparam logic signed [T_BITS-1:0] X_MIN = {1'b1, {(T_BITS-1){1'b0}}};

    logic signed [T_BITS-1:0] m_s;
    logic signed [ACC_W-1:0]  m_ext_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [S1_W-1:0]   stage1_next_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [S1_W-1:0]   stage1_r;

    // Mixer: pass, zero or negate; negating the most negative code saturates.
    always_comb begin
        m_s = {T_BITS{1'b0}};
        case (lo)
            LO_POS: m_s = x;
            LO_NEG: begin
                if (x == X_MIN) begin
                    m_s = X_MAX;
                end else begin
                    m_s = -x;
                end
            end
            default: m_s = {T_BITS{1'b0}};
        endcase
    end

    // Running sum and the floor-shifted dump value (drop SHIFT low bits).
    always_comb begin
        m_ext_s       = {{(ACC_W-T_BITS){m_s[T_BITS-1]}}, m_s};
        sum_s         = acc_r + m_ext_s;
        stage1_next_s = sum_s[SHIFT +: S1_W];
    end

    // Accumulator and stage-1 register; a restart discards the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {ACC_W{1'b0}};
            stage1_r <= {S1_W{1'b0}};
        end else if (restart && accept) begin
            acc_r <= m_ext_s;
        end else if (restart) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (accept && dump) begin
            acc_r    <= {ACC_W{1'b0}};
            stage1_r <= stage1_next_s;
        end else if (accept) begin
            acc_r <= sum_s;
        end
    end

    assign stage1 = stage1_r;

endmodule

// File: rtl/ddc_demixer.sv
// ddc_demixer
// Receive-side fs/4 quadrature demixer with integrate-and-dump decimation by
// 2^LOG2_DEC and a gain stage undoing the transmit amplitude scale.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ddc_demixer_if.slave (in_i, in_valid, sync_i -> out_i, out_q, out_valid)
// Pipeline after the accepting edge of a dumping sample: stage-1 register,
// product register, saturated output register with out_valid.
module ddc_demixer
    import ddc_demixer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ddc_demixer_if.slave bus
);

    localparam int S1_W   = T_BITS + 1;
    localparam int PROD_W = S1_W + GAIN_BITS;

    logic [1:0]              phase_r;
    logic [LOG2_DEC-1:0]     count_r;
    logic [1:0]              eff_phase_s;
    lo_code_e                lo_i_s;
    lo_code_e                lo_q_s;
    logic                    dump_s;
    logic signed [S1_W-1:0]  stage1_i_s;
    logic signed [S1_W-1:0]  stage1_q_s;
    logic signed [PROD_W-1:0] prod_i_s;
    logic signed [PROD_W-1:0] prod_q_s;
    logic                    dump_r;
    logic signed [PROD_W-1:0] prod_i_r;
    logic signed [PROD_W-1:0] prod_q_r;
    logic                    prod_valid_r;
    logic signed [T_BITS-1:0] out_i_r;
    logic signed [T_BITS-1:0] out_q_r;
    logic                    out_valid_r;

    // Arithmetic shift by F_BITS then clamp to the T_BITS signed range.
    function automatic logic signed [T_BITS-1:0] sat_out(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] v;
        logic signed [PROD_W-1:0] max_v;
        logic signed [PROD_W-1:0] min_v;
        logic signed [T_BITS-1:0] r;
        v     = p >>> F_BITS;
        max_v = {{(PROD_W-T_BITS+1){1'b0}}, {(T_BITS-1){1'b1}}};
        min_v = {{(PROD_W-T_BITS+1){1'b1}}, {(T_BITS-1){1'b0}}};
        if (v > max_v) begin
            r = {1'b0, {(T_BITS-1){1'b1}}};
        end else if (v < min_v) begin
            r = {1'b1, {(T_BITS-1){1'b0}}};
        end else begin
            r = v[T_BITS-1:0];
        end
        return r;
    endfunction

    // LO selection; a sync sample is always treated as phase 0 of a new frame,
    // and it never closes the frame it discards.
    always_comb begin
        eff_phase_s = phase_r;
        if (bus.sync_i) begin
            eff_phase_s = 2'd0;
        end else begin
            eff_phase_s = phase_r;
        end
        lo_i_s = lo_i_code(eff_phase_s);
        lo_q_s = lo_q_code(eff_phase_s);
        dump_s = bus.in_valid && !bus.sync_i && (count_r == {LOG2_DEC{1'b1}});
    end

    // LO phase and decimation counter, advanced only by accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 2'd0;
            count_r <= {LOG2_DEC{1'b0}};
        end else if (bus.sync_i && bus.in_valid) begin
            phase_r <= 2'd1;
            count_r <= {{(LOG2_DEC-1){1'b0}}, 1'b1};
        end else if (bus.sync_i) begin
            phase_r <= 2'd0;
            count_r <= {LOG2_DEC{1'b0}};
        end else if (bus.in_valid) begin
            phase_r <= phase_r + 2'd1;
            count_r <= count_r + {{(LOG2_DEC-1){1'b0}}, 1'b1};
        end
    end

    ddc_integrator u_int_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (bus.in_i),
        .lo      (lo_i_s),
        .accept  (bus.in_valid),
        .restart (bus.sync_i),
        .dump    (dump_s),
        .stage1  (stage1_i_s)
    );

    ddc_integrator u_int_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (bus.in_i),
        .lo      (lo_q_s),
        .accept  (bus.in_valid),
        .restart (bus.sync_i),
        .dump    (dump_s),
        .stage1  (stage1_q_s)
    );

    // Full-precision gain products of the stage-1 values.
    always_comb begin
        prod_i_s = stage1_i_s * $signed(GAIN);
        prod_q_s = stage1_q_s * $signed(GAIN);
    end

    // Gain and output stages; sync does not touch them so pending pairs complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_r       <= 1'b0;
            prod_i_r     <= {PROD_W{1'b0}};
            prod_q_r     <= {PROD_W{1'b0}};
            prod_valid_r <= 1'b0;
            out_i_r      <= {T_BITS{1'b0}};
            out_q_r      <= {T_BITS{1'b0}};
            out_valid_r  <= 1'b0;
        end else begin
            dump_r       <= dump_s;
            prod_valid_r <= dump_r;
            out_valid_r  <= prod_valid_r;
            if (dump_r) begin
                prod_i_r <= prod_i_s;
                prod_q_r <= prod_q_s;
            end
            if (prod_valid_r) begin
                out_i_r <= sat_out(prod_i_r);
                out_q_r <= sat_out(prod_q_r);
            end
        end
    end

    assign bus.out_i     = out_i_r;
    assign bus.out_q     = out_q_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_ddc_demixer.sv
// tb_ddc_demixer
// Directed, table-driven bench for ddc_demixer plus hand-written sequences for
// gapped valid, sync mid-frame, pending output across sync and reset mid-frame.
module tb_ddc_demixer;
    import ddc_demixer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ddc_demixer_if bus();

    ddc_demixer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string name;
        int    smp [8];
        int    exp_i;
        int    exp_q;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic step(input int x, input logic v, input logic s);
        bus.in_i     = x[T_BITS-1:0];
        bus.in_valid = v;
        bus.sync_i   = s;
        @(posedge clk);
        #1;
    endtask

    // Apply table entry k as one frame (optionally with an idle cycle before each
    // sample) and check that the pulse lands exactly two edges after the 8th sample.
    task automatic run_frame(input int k, input bit gap, input string nm);
        int early;
        early = 0;
        for (int j = 0; j < 8; j++) begin
            if (gap) begin
                step(0, 1'b0, 1'b0);
                if (bus.out_valid) early++;
            end
            step(vecs[k].smp[j], 1'b1, 1'b0);
            if (bus.out_valid) early++;
        end
        check({nm, " early pulse"}, early, 0);
        step(0, 1'b0, 1'b0);
        check({nm, " valid lat1"}, bus.out_valid, 0);
        step(0, 1'b0, 1'b0);
        check({nm, " valid lat2"}, bus.out_valid, 1);
        check({nm, " out_i"}, bus.out_i, vecs[k].exp_i);
        check({nm, " out_q"}, bus.out_q, vecs[k].exp_q);
        step(0, 1'b0, 1'b0);
        check({nm, " pulse width"}, bus.out_valid, 0);
    endtask

    int pulses;
    int first_at;
    int second_at;
    int tone [8];

    initial begin
        vecs[0]  = '{"zero",     '{0, 0, 0, 0, 0, 0, 0, 0},                 0,     0};
        vecs[1]  = '{"tone_i",   '{80, 0, -80, 0, 80, 0, -80, 0},           253,   0};
        vecs[2]  = '{"tone_q",   '{0, 80, 0, -80, 0, 80, 0, -80},           0,     253};
        vecs[3]  = '{"sat_i",    '{1023, 0, -1024, 0, 1023, 0, -1024, 0},   1023,  0};
        vecs[4]  = '{"sat_q",    '{0, 1023, 0, -1024, 0, 1023, 0, -1024},   0,     1023};
        vecs[5]  = '{"neg_tone", '{-80, 0, 80, 0, -80, 0, 80, 0},           -254,  0};
        vecs[6]  = '{"neg_sat",  '{-1024, 0, 1023, 0, -1024, 0, 1023, 0},   -1024, 0};
        vecs[7]  = '{"dc",       '{100, 100, 100, 100, 100, 100, 100, 100}, 0,     0};
        vecs[8]  = '{"small",    '{4, 0, -4, 0, 4, 0, -4, 0},               12,    0};
        vecs[9]  = '{"ramp",     '{10, 20, 30, 40, 50, 60, 70, 80},         -32,   -32};
        vecs[10] = '{"asym",     '{200, 7, 100, -3, 200, 7, 100, -3},       158,   15};
        tone = '{80, 0, -80, 0, 80, 0, -80, 0};

        rst_n        = 1'b0;
        bus.in_i     = '0;
        bus.in_valid = 1'b0;
        bus.sync_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_i", bus.out_i, 0);
        check("reset out_q", bus.out_q, 0);
        check("reset out_valid", bus.out_valid, 0);
        rst_n = 1'b1;

        // Table-driven frames, each aligned by an idle sync cycle.
        for (int k = 0; k < NVEC; k++) begin
            step(0, 1'b0, 1'b1);
            run_frame(k, 1'b0, vecs[k].name);
        end

        // Gapped valid: same tone, in_valid low every other cycle.
        step(0, 1'b0, 1'b1);
        run_frame(1, 1'b1, "gapped");

        // Output holds between dumps.
        repeat (5) step(0, 1'b0, 1'b0);
        check("hold out_i", bus.out_i, 253);

        // 16 zero samples back to back: two pulses, outputs return to 0.
        step(0, 1'b0, 1'b1);
        pulses = 0; first_at = -1; second_at = -1;
        for (int n = 0; n < 19; n++) begin
            if (n < 16) step(0, 1'b1, 1'b0);
            else        step(0, 1'b0, 1'b0);
            if (bus.out_valid) begin
                pulses++;
                if (first_at < 0) first_at = n;
                else              second_at = n;
                check("zero16 out_i", bus.out_i, 0);
                check("zero16 out_q", bus.out_q, 0);
            end
        end
        check("zero16 pulses", pulses, 2);
        check("zero16 first at", first_at, 9);
        check("zero16 second at", second_at, 17);

        // Sync mid-frame: 3 tone samples, sync with 80, then 7 more tone samples.
        step(0, 1'b0, 1'b1);
        pulses = 0;
        step(80, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);
        step(-80, 1'b1, 1'b0);
        step(80, 1'b1, 1'b1);
        if (bus.out_valid) pulses++;
        for (int j = 1; j < 8; j++) begin
            step(tone[j], 1'b1, 1'b0);
            if (bus.out_valid) pulses++;
        end
        step(0, 1'b0, 1'b0);
        if (bus.out_valid) pulses++;
        check("sync early pulse", pulses, 0);
        step(0, 1'b0, 1'b0);
        check("sync valid", bus.out_valid, 1);
        check("sync out_i", bus.out_i, 253);
        check("sync out_q", bus.out_q, 0);

        // A pending output completes across a sync cycle.
        step(0, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) step(-tone[j], 1'b1, 1'b0);
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0);
        check("pending valid", bus.out_valid, 1);
        check("pending out_i", bus.out_i, -254);

        // Reset mid-frame: outputs clear at once, fresh frame needs 8 new samples.
        step(0, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) step(tone[j], 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst out_i", bus.out_i, 0);
        check("rst out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            step(tone[j], 1'b1, 1'b0);
            if (bus.out_valid) pulses++;
        end
        step(0, 1'b0, 1'b0);
        if (bus.out_valid) pulses++;
        check("rst early pulse", pulses, 0);
        step(0, 1'b0, 1'b0);
        check("rst valid", bus.out_valid, 1);
        check("rst out_i", bus.out_i, 253);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddc_demixer.md
Name: ddc_demixer

Overview:
- Receive-side counterpart of the transmit upconverting mixer. Consumes a stream of real samples modulated onto an fs/4 carrier and mixes them to baseband with a quadrature LO (I: +1,0,-1,0; Q: 0,+1,0,-1).
- Integrate-and-dump decimates by DEC = 2^LOG2_DEC. A gain multiply undoes the transmit amplitude scale (0.3155).
- Emits one I/Q pair per DEC accepted samples, with a valid pulse.
- Sits after the sample source in the loopback/receive path. Feeds baseband consumers.

Parameters:
- T_BITS, 11, sample width. Signed fixed point. Shared with transmit path.
- F_BITS, 9, fractional bits of the sample and gain formats.
- LOG2_DEC, 3, log2 of the decimation factor. Legal range 2..6, so DEC is a multiple of 4 and the LO completes whole cycles.
- GAIN_BITS, 13, width of the signed gain constant.
- GAIN, 13'd1623, amplitude-correction gain: 1/0.3155 in Q(F_BITS) = 3.1699.

Ports:
- clk  in  1  Sole clock, rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- in_i  in  T_BITS  Signed input sample.
- in_valid  in  1  Sample qualifier. No backpressure; every valid sample is accepted.
- sync_i  in  1  Resynchronises LO phase and decimation frame.
- out_i  out  T_BITS  Signed baseband I.
- out_q  out  T_BITS  Signed baseband Q.
- out_valid  out  1  One-cycle pulse per decimated pair.

Behaviour:
- Reset (async, rst_n=0):
  - phase=0, count=0, acc_i=acc_q=0, stage-1 registers=0.
  - out_i=out_q=0, out_valid=0.
  - Release is synchronous to clk.
- LO phase (2-bit counter):
  - Advances only on cycles with in_valid=1. Idle cycles freeze phase, count and accumulators.
  - I LO by phase 0..3: +1, 0, -1, 0.
  - Q LO by phase 0..3: 0, +1, 0, -1.
  - Wraps 3 -> 0.
- Mixing:
  - m = +x, 0, or -x depending on the LO value.
  - -x saturates: -(-1024) = +1023.
- Accumulators: signed, width T_BITS+LOG2_DEC. Cannot overflow.
- Decimation counter (LOG2_DEC bits): increments per accepted sample.
- Dump, on the accepted sample where count = DEC-1:
  - stage1 = (acc + m) >>> (LOG2_DEC-1), arithmetic shift, floor. The factor 2 compensates the 1/2 mixing loss.
  - acc is cleared to 0 (not loaded with m).
  - count wraps to 0.
- Stage 2 (next clock edge):
  - p = stage1 * GAIN, full precision.
  - out = sat_T_BITS(p >>> F_BITS), clamped to [-1024, +1023].
  - out_valid=1 for exactly one cycle.
- Latency: out_valid is high in the cycle following the second rising edge after the edge that accepts the dumping sample. out_i/out_q hold their value until the next dump.
- sync_i:
  - sync_i=1 with in_valid=0: phase, count and accumulators are cleared.
  - sync_i=1 with in_valid=1: the accepted sample is processed as phase 0, count 0 of a fresh frame. The partial frame is discarded; no dump occurs for it.
  - A pending stage-2 output still completes.
- Reset mid-frame: all state cleared immediately. Any in-flight output is lost. No out_valid until DEC new samples have been accepted.

Decomposition:
- Shared package / parameters header:
  - T_BITS, F_BITS and the transmit amplitude constant.
  - GAIN constant and LO code encoding: 2'b01=+1, 2'b10=-1, 2'b00=0. Same encoding as the transmit LO.
- One natural sub-module: ddc_integrator.
  - Instantiated twice (I and Q).
  - Contains the sign/zero select, accumulator, dump shift and stage-1 register.
  - Phase/count control lives in the top.

Test Plan:
- Zero input: 16 samples of 0 -> two out_valid pulses, out_i=out_q=0.
- Tone on I: repeat 80, 0, -80, 0 for 8 samples with continuous valid.
  - Expect out_i=253, out_q=0.
  - out_valid exactly 2 cycles after the 8th sample's edge.
- Saturation: I-pattern 1023, 0, -1024, 0 -> out_i=1023 (clamped). Q-pattern 0, 1023, 0, -1024 -> out_q=1023.
- Gapped valid: same tone as the tone-on-I case, with in_valid low every other cycle -> identical outputs, with pulse timing keyed to the 8th accepted sample.
- Sync mid-frame: 3 tone samples, then sync_i=1 together with sample value 80, then the tone continues -> no pulse until 8 samples counted from the sync sample; out_i=253.
- Reset mid-frame: assert rst_n=0 after 5 samples -> outputs 0 immediately. After release, the first pulse occurs only after 8 new samples.
